cache_maint_seq: RTL and testbench

- Maintenance sequencer for the 4-way L1 cache; it executes the FLUSH_ALL and INVAL_ALL operations.
- Walks every index of the valid/dirty register files, tag RAMs and data SRAMs.
- Writes dirty lines back to main memory over a req/ack port, then clears valid, dirty and LRU state per set.
- Sits beside the main cache FSM, which hands it the array ports while busy=1.

---
 rtl/cache_maint_pkg.sv | 28 ++
 rtl/way_pick.sv | 28 ++
 rtl/cache_maint_seq.sv | 182 ++++++++++++++++++
 tb/tb_cache_maint_seq.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_maint_pkg.sv
// Shared constants for the L1 cache maintenance sequencer.
// Holds default array widths matching the cache top, the sequencer state
// encodings and the maintenance opcode values.
package cache_maint_pkg;

    // Default geometry of the 4-way L1 (8192 sets, 32-byte lines).
    localparam int WAYS_DEF      = 4;
    localparam int IDX_BITS_DEF  = 13;
    localparam int TAG_BITS_DEF  = 14;
    localparam int OFF_BITS_DEF  = 5;
    localparam int LINE_BITS_DEF = 256;
    localparam int ADDR_BITS     = 32;

    // Sequencer states, kept as plain constants so legacy tools that
    // predate enum support can still read the encoding.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RD_SET  = 3'd1;
    localparam state_t ST_CHK_SET = 3'd2;
    localparam state_t ST_RD_WAY  = 3'd3;
    localparam state_t ST_WB_REQ  = 3'd4;
    localparam state_t ST_CLR     = 3'd5;

    // Maintenance opcodes carried on cmd_op.
    localparam logic OP_FLUSH = 1'b0;  // write back dirty lines, then invalidate
    localparam logic OP_INVAL = 1'b1;  // invalidate only, dirty data discarded

endpackage

// File: rtl/way_pick.sv
// Purpose: one-hot select of the lowest set bit of a WAYS-wide request mask.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input every cycle.
//
// Ports: req  - candidate way mask
//        gnt  - one-hot lowest set bit of req, all zero when req is zero
// Shared with the replacement logic, which uses it to pick a free way.
module way_pick #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-1:0] req,
    output logic [WAYS-1:0] gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (req[i] && !found) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_maint_seq.sv
// Purpose: walks every L1 set for FLUSH_ALL / INVAL_ALL, writing back dirty lines and clearing state.
// Latency: 3 cycles per clean set, plus 2 cycles and the ack wait per dirty way; done 1 cycle after last clear.
// Backpressure: cmd_ready only in IDLE (commands wait upstream); wb_req/addr/data held until wb_ack.
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   cmd_valid/cmd_op/cmd_ready - command handshake; cmd_op 0=FLUSH, 1=INVAL
//   busy, done                 - walk in progress / one-cycle completion pulse
//   idx, arr_rd, way_sel       - array address, read strobe, one-hot way (0 for set reads)
//   val_rd, mod_rd             - valid/dirty bits of idx, one cycle after arr_rd
//   tag_rd, line_rd            - tag and line of way_sel, one cycle after arr_rd
//   wb_req/wb_addr/wb_data/wb_ack - writeback request port to main memory
//   val_clr, mod_clr, lru_rst  - one-cycle clear strobes for the set at idx
module cache_maint_seq
    import cache_maint_pkg::*;
#(
    parameter int WAYS      = WAYS_DEF,
    parameter int IDX_BITS  = IDX_BITS_DEF,
    parameter int TAG_BITS  = TAG_BITS_DEF,
    parameter int OFF_BITS  = OFF_BITS_DEF,
    parameter int LINE_BITS = LINE_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 cmd_valid,
    input  logic                 cmd_op,
    output logic                 cmd_ready,
    output logic                 busy,
    output logic                 done,

    output logic [IDX_BITS-1:0]  idx,
    output logic                 arr_rd,
    output logic [WAYS-1:0]      way_sel,
    input  logic [WAYS-1:0]      val_rd,
    input  logic [WAYS-1:0]      mod_rd,
    input  logic [TAG_BITS-1:0]  tag_rd,
    input  logic [LINE_BITS-1:0] line_rd,

    output logic                 wb_req,
    output logic [31:0]          wb_addr,
    output logic [LINE_BITS-1:0] wb_data,
    input  logic                 wb_ack,

    output logic [WAYS-1:0]      val_clr,
    output logic [WAYS-1:0]      mod_clr,
    output logic                 lru_rst
);

    state_t                state_q,   state_d;
    logic [IDX_BITS-1:0]   idx_q,     idx_d;
    logic [WAYS-1:0]       pend_q,    pend_d;
    logic                  op_q,      op_d;
    logic                  wb_req_q,  wb_req_d;
    logic [31:0]           wb_addr_q, wb_addr_d;
    logic [LINE_BITS-1:0]  wb_data_q, wb_data_d;
    logic                  done_q,    done_d;

    // Way currently being written back: lowest outstanding dirty way.
    logic [WAYS-1:0]       pick;

    way_pick #(
        .WAYS (WAYS)
    ) u_way_pick (
        .req (pend_q),
        .gnt (pick)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        op_d      = op_q;
        wb_req_d  = wb_req_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    idx_d   = '0;
                    pend_d  = '0;
                    state_d = ST_RD_SET;
                end
            end

            ST_RD_SET: begin
                state_d = ST_RD_SET + state_t'(1);
            end

            ST_CHK_SET: begin
                // Only lines that are both valid and dirty need writing back;
                // a stale dirty bit on an invalid way is ignored.
                pend_d  = (op_q == OP_INVAL) ? '0 : (val_rd & mod_rd);
                state_d = (pend_d == '0) ? ST_CLR : ST_RD_WAY;
            end

            ST_RD_WAY: begin
                state_d = ST_WB_REQ;
            end

            ST_WB_REQ: begin
                if (!wb_req_q) begin
                    // First cycle here: tag/line read issued in RD_WAY has
                    // just arrived, so capture it before raising the request.
                    wb_addr_d = ADDR_BITS'({tag_rd, idx_q, {OFF_BITS{1'b0}}});
                    wb_data_d = line_rd;
                    wb_req_d  = 1'b1;
                end else if (wb_ack) begin
                    wb_req_d = 1'b0;
                    pend_d   = pend_q & ~pick;
                    state_d  = (pend_d != '0) ? ST_RD_WAY : ST_CLR;
                end
            end

            ST_CLR: begin
                // Terminate on the last index instead of relying on wrap.
                if (idx_q == {IDX_BITS{1'b1}}) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_BITS'(1);
                    state_d = ST_RD_SET;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                wb_req_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            pend_q    <= '0;
            op_q      <= OP_FLUSH;
            wb_req_q  <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            op_q      <= op_d;
            wb_req_q  <= wb_req_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            done_q    <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        done      = done_q;
        idx       = idx_q;
        arr_rd    = (state_q == ST_RD_SET) || (state_q == ST_RD_WAY);
        way_sel   = (state_q == ST_RD_WAY) ? pick : '0;
        wb_req    = wb_req_q;
        wb_addr   = wb_addr_q;
        wb_data   = wb_data_q;
        val_clr   = {WAYS{state_q == ST_CLR}};
        mod_clr   = {WAYS{state_q == ST_CLR}};
        lru_rst   = (state_q == ST_CLR);
    end

endmodule

// File: tb/tb_cache_maint_seq.sv
module tb_cache_maint_seq;
    import cache_maint_pkg::*;

    localparam int WAYS      = 4;
    localparam int IDX_BITS  = 3;
    localparam int TAG_BITS  = 14;
    localparam int OFF_BITS  = 5;
    localparam int LINE_BITS = 256;
    localparam int NSETS     = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cmd_valid, cmd_op, cmd_ready, busy, done;
    logic [IDX_BITS-1:0]  idx;
    logic                 arr_rd;
    logic [WAYS-1:0]      way_sel;
    logic [WAYS-1:0]      val_rd = '0, mod_rd = '0;
    logic [TAG_BITS-1:0]  tag_rd = '0;
    logic [LINE_BITS-1:0] line_rd = '0;
    logic                 wb_req, wb_ack;
    logic [31:0]          wb_addr;
    logic [LINE_BITS-1:0] wb_data;
    logic [WAYS-1:0]      val_clr, mod_clr;
    logic                 lru_rst;

    cache_maint_seq #(
        .WAYS(WAYS), .IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS),
        .OFF_BITS(OFF_BITS), .LINE_BITS(LINE_BITS)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .busy(busy), .done(done),
        .idx(idx), .arr_rd(arr_rd), .way_sel(way_sel),
        .val_rd(val_rd), .mod_rd(mod_rd), .tag_rd(tag_rd), .line_rd(line_rd),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack),
        .val_clr(val_clr), .mod_clr(mod_clr), .lru_rst(lru_rst)
    );

    always #5 clk = ~clk;

    // Array contents seen by the sequencer
    logic [WAYS-1:0]      val_mem  [NSETS];
    logic [WAYS-1:0]      mod_mem  [NSETS];
    logic [TAG_BITS-1:0]  tag_mem  [NSETS][WAYS];
    logic [LINE_BITS-1:0] line_mem [NSETS][WAYS];

    // One-cycle read latency array model
    always @(posedge clk) begin
        if (arr_rd) begin
            val_rd <= val_mem[idx];
            mod_rd <= mod_mem[idx];
            for (int w = 0; w < WAYS; w++) begin
                if (way_sel[w]) begin
                    tag_rd  <= tag_mem[idx][w];
                    line_rd <= line_mem[idx][w];
                end
            end
        end
    end

    // Memory responder: acks after wb_req has been high ack_delay cycles
    logic ack_auto = 1'b0;
    logic ack_stray = 1'b0;
    logic ack_en = 1'b1;
    int   ack_delay = 3;
    int   ack_cnt = 0;
    assign wb_ack = ack_auto | ack_stray;

    always @(posedge clk) begin
        if (reset || !wb_req || ack_auto) begin
            ack_cnt  <= 0;
            ack_auto <= 1'b0;
        end else if (ack_en) begin
            if (ack_cnt + 1 >= ack_delay) ack_auto <= 1'b1;
            else                          ack_cnt  <= ack_cnt + 1;
        end
    end

    // Scoreboard
    typedef struct packed {
        logic [31:0]          addr;
        logic [LINE_BITS-1:0] data;
    } wb_exp_t;

    wb_exp_t             wb_q[$];
    logic [IDX_BITS-1:0] clr_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        wb_exp_t             e;
        logic [IDX_BITS-1:0] ci;
        if (reset === 1'b0) begin
            check_eq("busy_and_ready", busy & cmd_ready, 1'b0);
            check_eq("done_and_busy", done & busy, 1'b0);
            if (wb_req && wb_ack) begin
                if (wb_q.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL wb_unexpected observed addr=%0h expected=none", wb_addr);
                end else begin
                    e = wb_q.pop_front();
                    check_eq("wb_addr", wb_addr, e.addr);
                    check_eq("wb_data", wb_data, e.data);
                end
            end
            if (val_clr != '0 || mod_clr != '0 || lru_rst) begin
                if (clr_q.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL clr_unexpected observed idx=%0d expected=none", idx);
                end else begin
                    ci = clr_q.pop_front();
                    check_eq("clr_idx", idx, ci);
                    check_eq("clr_val", val_clr, 4'hF);
                    check_eq("clr_mod", mod_clr, 4'hF);
                    check_eq("clr_lru", lru_rst, 1'b1);
                end
            end
        end
    end

    task automatic fill(input logic [WAYS-1:0] v, input logic [WAYS-1:0] m);
        for (int s = 0; s < NSETS; s++) begin
            val_mem[s] = v;
            mod_mem[s] = m;
            for (int w = 0; w < WAYS; w++) begin
                tag_mem[s][w]  = TAG_BITS'($urandom());
                line_mem[s][w] = {$urandom(), $urandom(), $urandom(), $urandom(),
                                  $urandom(), $urandom(), $urandom(), $urandom()};
            end
        end
    endtask

    task automatic push_clr_all();
        for (int i = 0; i < NSETS; i++) clr_q.push_back(IDX_BITS'(i));
    endtask

    task automatic push_wb(input int s, input int w);
        wb_exp_t e;
        logic [TAG_BITS-1:0] t;
        logic [IDX_BITS-1:0] ix;
        t  = tag_mem[s][w];
        ix = IDX_BITS'(s);
        e.addr = 32'({t, ix, {OFF_BITS{1'b0}}});
        e.data = line_mem[s][w];
        wb_q.push_back(e);
    endtask

    task automatic issue(input logic op);
        @(negedge clk);
        check_eq("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int n = 0;
        logic seen = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, "_done_seen"}, seen, 1'b1);
        if (exp_cyc > 0) check_eq({tag, "_done_cycle"}, n, exp_cyc);
        check_eq({tag, "_busy_at_done"}, busy, 1'b0);
        check_eq({tag, "_ready_at_done"}, cmd_ready, 1'b1);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, done, 1'b0);
        check_eq({tag, "_wb_q_empty"}, wb_q.size(), 0);
        check_eq({tag, "_clr_q_empty"}, clr_q.size(), 0);
    endtask

    initial begin
        logic seen;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_FLUSH;
        fill('0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd_ready", cmd_ready, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_wb_req", wb_req, 1'b0);
        check_eq("rst_arr_rd", arr_rd, 1'b0);
        check_eq("rst_idx", idx, 3'd0);
        check_eq("rst_val_clr", val_clr, 4'h0);
        check_eq("rst_lru", lru_rst, 1'b0);
        reset = 1'b0;

        // INVAL over fully valid+dirty arrays: no writebacks, 8 clears, done at 25
        fill(4'hF, 4'hF);
        push_clr_all();
        issue(OP_INVAL);
        wait_done("inval", 25);

        // FLUSH with two dirty ways in set 2; commands during the walk are refused
        fill('0, '0);
        val_mem[2] = 4'b0101;
        mod_mem[2] = 4'b0101;
        tag_mem[2][0] = 14'h1A5;
        tag_mem[2][2] = 14'h0C3;
        push_wb(2, 0);
        push_wb(2, 2);
        push_clr_all();
        ack_delay = 3;
        issue(OP_FLUSH);
        cmd_valid = 1'b1;
        cmd_op    = OP_INVAL;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("walk_cmd_ready", cmd_ready, 1'b0);
            check_eq("walk_busy", busy, 1'b1);
        end
        cmd_valid = 1'b0;
        wait_done("flush2", 0);

        // FLUSH where dirty bits sit on invalid ways: nothing written back
        fill(4'b0000, 4'b1000);
        push_clr_all();
        issue(OP_FLUSH);
        wait_done("flush_clean", 25);

        // Reset while a writeback is outstanding and unacknowledged
        fill('0, '0);
        val_mem[0] = 4'b0001;
        mod_mem[0] = 4'b0001;
        ack_en = 1'b0;
        issue(OP_FLUSH);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (wb_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("rstwb_req_seen", seen, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rstwb_wb_req", wb_req, 1'b0);
        check_eq("rstwb_ready", cmd_ready, 1'b1);
        check_eq("rstwb_val_clr", val_clr, 4'h0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rstwb_idle_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        ack_en = 1'b1;

        // Stray ack while no request is pending, then a genuine one
        fill('0, '0);
        val_mem[0] = 4'b0010;
        mod_mem[0] = 4'b0010;
        tag_mem[0][1] = 14'h2B;
        push_wb(0, 1);
        push_clr_all();
        ack_en = 1'b0;
        issue(OP_FLUSH);
        @(negedge clk);
        ack_stray = 1'b1;
        @(negedge clk);
        ack_stray = 1'b0;
        check_eq("stray_busy", busy, 1'b1);
        check_eq("stray_wb_req", wb_req, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wb_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("stray_req_seen", seen, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("stray_req_held", wb_req, 1'b1);
        check_eq("stray_busy_held", busy, 1'b1);
        ack_en = 1'b1;
        wait_done("stray", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
